mc_control_fsm: RTL
===================

// Module: mc_control_fsm
// PURPOSE
//  Multi-cycle control sequencer for the RV32I core datapath (IR, PC, regfile, imm generator, ALU, ALUOut reg, memory port).
//  Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives every datapath select and write-enable.
//  Selects the immediate format, waits on the memory handshake, and traps on illegal opcodes or memory timeout.
// PARAMETERS
//  TIMEOUT   256  max mem wait cycles per request; reaching it -> TRAP
//  CNT_W     8    wait-counter width; must satisfy 2**CNT_W >= TIMEOUT
// PORTS
//  clk          in   1   single clock, rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  instr        in   32  IR contents; valid from DECODE until the next FETCH
//  br_taken     in   1   branch comparator result (rs1 vs rs2, funct3); sampled in EXEC
//  mem_ready    in   1   memory ack; completes the current mem_req in the same cycle
//  mem_req      out  1   memory request, held high until mem_ready
//  mem_we       out  1   store write (only with mem_req in MEM)
//  mem_is_fetch out  1   1 = address from PC, 0 = address from ALUOut
//  ir_we        out  1   load IR from memory read data
//  pc_we        out  1   PC write strobe
//  pc_sel       out  2   0 PC+4, 1 ALU result (branch/JAL target), 2 ALU result & ~1 (JALR)
//  imm_sel      out  3   0 I, 1 S, 2 B, 3 J, 4 U
//  alu_a_sel    out  1   0 rs1, 1 PC
//  alu_b_sel    out  1   0 rs2, 1 imm
//  alu_op       out  4   ALU operation (encoding in package)
//  alu_out_we   out  1   latch ALUOut register
//  reg_we       out  1   register file write
//  wb_sel       out  2   0 ALUOut, 1 mem read data, 2 PC+4
//  trap         out  1   sticky fault flag
//  state_o      out  3   current state (debug)
// BEHAVIOUR
//  States: IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 TRAP=6. All outputs decoded from state + instr (+ mem_ready/br_taken where noted).
//  Reset: state=IDLE, wait counter=0; every output 0 (state_o=0). IDLE -> FETCH unconditionally after one cycle.
//  FETCH: mem_req=1, mem_is_fetch=1; on mem_ready: ir_we=1 -> DECODE; else stay.
//  DECODE (1 cycle): imm_sel from instr[6:0]: 0010011/0000011/1100111 I; 0100011 S; 1100011 B; 1101111 J; 0110111/0010111 U;
//    0110011 R and 0001111 FENCE -> imm_sel 0 (don't care). Any other opcode (incl. 1110011 SYSTEM) -> TRAP.
//  EXEC (1 cycle, alu_out_we=1): R/I-ALU: a=rs1, b=rs2|imm, alu_op={instr[30]&(R|shift-imm), funct3}; LUI: alu_op=PASSB, b=imm;
//    AUIPC/JAL/branch: a=PC, b=imm, ADD; JALR/load/store: a=rs1, b=imm, ADD.
//    Branch: pc_we=1, pc_sel=br_taken?1:0 -> FETCH. Load/store -> MEM. FENCE: pc_we=1, pc_sel=0 -> FETCH. Others -> WB.
//  MEM: mem_req=1, mem_is_fetch=0, mem_we=store. On mem_ready: store -> pc_we=1, pc_sel=0 -> FETCH; load -> WB. Else stay.
//  WB (1 cycle): reg_we=(instr[11:7]!=0); wb_sel 1 load, 2 JAL/JALR, else 0; pc_we=1, pc_sel 1 JAL, 2 JALR, else 0 -> FETCH.
//  PC written exactly once per retired instruction. Zero-wait latency: branch/FENCE 3, ALU/U/JAL/JALR/store 4, load 5 cycles.
//  Wait counter: cleared on entry to FETCH/MEM and on every mem_ready; increments each cycle mem_req=1 && !mem_ready;
//    reaching TIMEOUT-1 with no ack -> TRAP next cycle (no ir_we/pc_we/reg_we issued). mem_ready=1 with mem_req=0 ignored.
//  TRAP: trap=1, all other outputs 0, state held until rst_n asserted.
//  rst_n asserted mid-instruction: immediate (async) return to IDLE, all strobes drop in the same cycle; partial instruction discarded.
// STRUCTURE
//  Package mc_ctrl_pkg: state enum, IMM_I/S/B/J/U codes, opcode constants, ALU_ADD=0000 SUB=1000 SLL=0001 SLT=0010
//    SLTU=0011 XOR=0100 SRL=0101 SRA=1101 OR=0110 AND=0111 PASSB=1111, PC_SEL_*, WB_SEL_* codes.
//  One sub-module: mc_ctrl_decode (combinational opcode -> class/imm_sel/alu_op/illegal); FSM and wait counter in top.
// TESTING
//  Reset, mem_ready=1 tied: ADDI x1,x0,5 (0x00500093) -> IDLE,FETCH,DECODE,EXEC,WB; imm_sel=0, alu_op=0000, reg_we=1 in WB only.
//  LW x2,4(x1) with 3 wait cycles in MEM -> mem_req held 4 cycles, mem_we=0, then WB with wb_sel=1, reg_we=1; total 8 cycles.
//  BEQ (0x00208463), br_taken=1 -> imm_sel=2, EXEC pc_we=1 pc_sel=1, back to FETCH, no reg_we; br_taken=0 -> pc_sel=0.
//  JALR x0,0(x1) -> WB wb_sel=2, pc_sel=2, reg_we=0 (rd=0); SW -> mem_we=1 in MEM, no WB state.
//  Opcode 0x7F or ECALL (0x00000073) in DECODE -> TRAP, trap=1, all strobes 0 for 20 cycles; rst_n low clears trap.
//  mem_ready held 0 in FETCH -> TRAP after TIMEOUT cycles, ir_we never asserted; rst_n pulsed low during MEM -> outputs 0 at once.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control sequencer.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        CL_ALU_R,
        CL_ALU_I,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_JAL,
        CL_JALR,
        CL_LUI,
        CL_AUIPC,
        CL_FENCE,
        CL_ILLEGAL
    } instr_class_t;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    localparam logic [6:0] OP_ALU_I  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_ALU_R  = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b1000;
    localparam logic [3:0] ALU_SLL   = 4'b0001;
    localparam logic [3:0] ALU_SLT   = 4'b0010;
    localparam logic [3:0] ALU_SLTU  = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SRL   = 4'b0101;
    localparam logic [3:0] ALU_SRA   = 4'b1101;
    localparam logic [3:0] ALU_OR    = 4'b0110;
    localparam logic [3:0] ALU_AND   = 4'b0111;
    localparam logic [3:0] ALU_PASSB = 4'b1111;

    localparam logic [1:0] PC_SEL_PC4  = 2'd0;
    localparam logic [1:0] PC_SEL_ALU  = 2'd1;
    localparam logic [1:0] PC_SEL_JALR = 2'd2;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;

endpackage

// File: rtl/mc_control_fsm_if.sv
// Memory port handshake between the sequencer (master) and memory (slave).
interface mc_control_fsm_if;
    logic mem_req;
    logic mem_we;
    logic mem_is_fetch;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output mem_is_fetch, input mem_ready);
    modport slave  (input mem_req, input mem_we, input mem_is_fetch, output mem_ready);
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode classifier: instruction class, immediate format, ALU op.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [31:0]   i_instr,
    output instr_class_t  o_class,
    output logic [2:0]    o_imm_sel,
    output logic [3:0]    o_alu_op,
    output logic          o_illegal
);

    logic [2:0] w_funct3;
    logic       w_shift;
    logic       w_unused_bits;

    assign w_funct3      = i_instr[14:12];
    assign w_shift       = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);
    // Remaining fields are consumed by the datapath, not by classification.
    assign w_unused_bits = ^{i_instr[31], i_instr[29:15], i_instr[11:7]};
    assign o_illegal     = (o_class == CL_ILLEGAL);

    // Map opcode to class, immediate format and ALU operation.
    always_comb begin
        o_class   = CL_ILLEGAL;
        o_imm_sel = IMM_I;
        o_alu_op  = ALU_ADD;
        case (i_instr[6:0])
            OP_ALU_R: begin
                o_class  = CL_ALU_R;
                o_alu_op = {i_instr[30], w_funct3};
            end
            OP_ALU_I: begin
                o_class  = CL_ALU_I;
                o_alu_op = {i_instr[30] & w_shift, w_funct3};
            end
            OP_LOAD:   o_class = CL_LOAD;
            OP_JALR:   o_class = CL_JALR;
            OP_STORE: begin
                o_class   = CL_STORE;
                o_imm_sel = IMM_S;
            end
            OP_BRANCH: begin
                o_class   = CL_BRANCH;
                o_imm_sel = IMM_B;
            end
            OP_JAL: begin
                o_class   = CL_JAL;
                o_imm_sel = IMM_J;
            end
            OP_LUI: begin
                o_class   = CL_LUI;
                o_imm_sel = IMM_U;
                o_alu_op  = ALU_PASSB;
            end
            OP_AUIPC: begin
                o_class   = CL_AUIPC;
                o_imm_sel = IMM_U;
            end
            OP_FENCE:  o_class = CL_FENCE;
            default:   o_class = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory wait timeout trap.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mc_control_fsm_if.master        mem_bus,
    input  logic [31:0]             instr,
    input  logic                    br_taken,
    output logic                    ir_we,
    output logic                    pc_we,
    output logic [1:0]              pc_sel,
    output logic [2:0]              imm_sel,
    output logic                    alu_a_sel,
    output logic                    alu_b_sel,
    output logic [3:0]              alu_op,
    output logic                    alu_out_we,
    output logic                    reg_we,
    output logic [1:0]              wb_sel,
    output logic                    trap,
    output logic [2:0]              state_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    instr_class_t     w_class;
    logic [2:0]       w_imm_sel;
    logic [3:0]       w_alu_op;
    logic             w_illegal;
    logic             w_timeout;
    logic             w_mem_req;
    logic             w_mem_we;
    logic             w_mem_is_fetch;

    mc_ctrl_decode u_decode (
        .i_instr   (instr),
        .o_class   (w_class),
        .o_imm_sel (w_imm_sel),
        .o_alu_op  (w_alu_op),
        .o_illegal (w_illegal)
    );

    assign w_timeout            = (r_cnt == CNT_LAST) && !mem_bus.mem_ready;
    assign mem_bus.mem_req      = w_mem_req;
    assign mem_bus.mem_we       = w_mem_we;
    assign mem_bus.mem_is_fetch = w_mem_is_fetch;
    assign state_o              = r_state;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Memory wait counter; any state change or ack clears it, which covers entry to FETCH/MEM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (w_mem_req && !mem_bus.mem_ready && (w_state_next == r_state))
            r_cnt <= r_cnt + CNT_W'(1);
        else
            r_cnt <= '0;
    end

    // Next-state and datapath control decode.
    always_comb begin
        w_state_next   = r_state;
        w_mem_req      = 1'b0;
        w_mem_we       = 1'b0;
        w_mem_is_fetch = 1'b0;
        ir_we          = 1'b0;
        pc_we          = 1'b0;
        pc_sel         = PC_SEL_PC4;
        imm_sel        = IMM_I;
        alu_a_sel      = 1'b0;
        alu_b_sel      = 1'b0;
        alu_op         = ALU_ADD;
        alu_out_we     = 1'b0;
        reg_we         = 1'b0;
        wb_sel         = WB_SEL_ALU;
        trap           = 1'b0;
        case (r_state)
            S_IDLE: w_state_next = S_FETCH;
            S_FETCH: begin
                w_mem_req      = 1'b1;
                w_mem_is_fetch = 1'b1;
                if (mem_bus.mem_ready) begin
                    ir_we        = 1'b1;
                    w_state_next = S_DECODE;
                end else if (w_timeout) begin
                    w_state_next = S_TRAP;
                end
            end
            S_DECODE: begin
                imm_sel      = w_imm_sel;
                w_state_next = w_illegal ? S_TRAP : S_EXEC;
            end
            S_EXEC: begin
                imm_sel    = w_imm_sel;
                alu_op     = w_alu_op;
                alu_out_we = 1'b1;
                case (w_class)
                    CL_ALU_I, CL_LOAD, CL_STORE, CL_JALR, CL_LUI: alu_b_sel = 1'b1;
                    CL_AUIPC, CL_JAL, CL_BRANCH: begin
                        alu_a_sel = 1'b1;
                        alu_b_sel = 1'b1;
                    end
                    default: ;
                endcase
                case (w_class)
                    CL_BRANCH: begin
                        pc_we        = 1'b1;
                        pc_sel       = br_taken ? PC_SEL_ALU : PC_SEL_PC4;
                        w_state_next = S_FETCH;
                    end
                    CL_FENCE: begin
                        pc_we        = 1'b1;
                        w_state_next = S_FETCH;
                    end
                    CL_LOAD, CL_STORE: w_state_next = S_MEM;
                    default:           w_state_next = S_WB;
                endcase
            end
            S_MEM: begin
                w_mem_req = 1'b1;
                w_mem_we  = (w_class == CL_STORE);
                if (mem_bus.mem_ready) begin
                    if (w_class == CL_STORE) begin
                        pc_we        = 1'b1;
                        w_state_next = S_FETCH;
                    end else begin
                        w_state_next = S_WB;
                    end
                end else if (w_timeout) begin
                    w_state_next = S_TRAP;
                end
            end
            S_WB: begin
                reg_we       = (instr[11:7] != 5'd0);
                pc_we        = 1'b1;
                w_state_next = S_FETCH;
                case (w_class)
                    CL_LOAD: wb_sel = WB_SEL_MEM;
                    CL_JAL: begin
                        wb_sel = WB_SEL_PC4;
                        pc_sel = PC_SEL_ALU;
                    end
                    CL_JALR: begin
                        wb_sel = WB_SEL_PC4;
                        pc_sel = PC_SEL_JALR;
                    end
                    default: ;
                endcase
            end
            S_TRAP:  trap = 1'b1;
            default: w_state_next = S_IDLE;
        endcase
    end

endmodule
